// File: rtl/uart_rx_port_pkg.sv
// Shared UART definitions: data width and receiver FSM encodings,
// also consumed by the transmit-side uart model.
package uart_rx_port_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

endpackage

// File: rtl/uart_rx_fifo.sv
// DEPTH x 8 receive FIFO with a combinational read of the head entry.
// A push into a full FIFO only lands when a pop frees a slot in the same cycle.
module uart_rx_fifo
  import uart_rx_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [UART_DATA_BITS-1:0] din,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      empty,
  output logic                      full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [AW:0]               count;
  logic                      do_push;
  logic                      do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: empty gates every read of it.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver port: synchroniser, bit FSM, sticky error flags and a
// tri-state read path onto the CPU data bus.
module uart_rx_port
  import uart_rx_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic                      i_clk,
  input  logic                      reset,
  input  logic                      rxd,
  input  logic                      rd_ena,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      rx_ready,
  output logic                      framing_err,
  output logic                      overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic [1:0]                sync;
  logic                      rxs;
  logic [2:0]                state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      stop_sample;
  logic                      push;
  logic                      pop;
  logic                      empty;
  logic                      full;
  logic                      overrun_set;
  logic                      framing_set;
  logic [UART_DATA_BITS-1:0] fifo_dout;

  assign rxs         = sync[1];
  assign stop_sample = (state == RX_STOP) && (cnt == BIT_LAST);
  assign push        = stop_sample && rxs;
  assign framing_set = stop_sample && !rxs;
  assign pop         = !rd_ena && !empty;
  assign overrun_set = push && full && !pop;
  assign rx_ready    = !empty;
  assign data_out    = rd_ena ? 8'hzz : (empty ? 8'h00 : fifo_dout);

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      sync      <= 2'b11;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      sync <= {sync[0], rxd};
      case (state)
        RX_IDLE: begin
          if (!rxs) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        // Mid-start-bit check rejects glitches shorter than half a bit.
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt       <= '0;
            shift_reg <= {rxs, shift_reg[UART_DATA_BITS-1:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) state <= RX_STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= rxs ? RX_IDLE : RX_BREAK;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RX_BREAK: begin
          if (rxs) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // A new error wins over a pop landing in the same cycle.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (framing_set)      framing_err <= 1'b1;
      else if (pop)         framing_err <= 1'b0;
      if (overrun_set)      overrun <= 1'b1;
      else if (pop)         overrun <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk (i_clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (shift_reg),
    .dout  (fifo_dout),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_uart_rx_port.sv
// Scoreboard bench for uart_rx_port: drives bit-accurate 8N1 frames and
// compares every read and flag against a queue-based reference.
module tb_uart_rx_port;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       i_clk;
  logic       rst_n;
  logic       rxd;
  logic       rd_ena;
  wire  [7:0] data_out;
  wire        rx_ready;
  wire        framing_err;
  wire        overrun;

  int         total;
  int         bad;
  logic [7:0] exp_q[$];
  logic       exp_ferr;
  logic       exp_ovr;
  int         lat;

  uart_rx_port #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH)
  ) dut (
    .i_clk      (i_clk),
    .reset      (rst_n),
    .rxd        (rxd),
    .rd_ena     (rd_ena),
    .data_out   (data_out),
    .rx_ready   (rx_ready),
    .framing_err(framing_err),
    .overrun    (overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; leaves the line idle high and updates the reference.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (CPB) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge i_clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge i_clk);
    rxd = 1'b1;
    if (!stop_bit)                  exp_ferr = 1'b1;
    else if (exp_q.size() < DEPTH)  exp_q.push_back(b);
    else                            exp_ovr = 1'b1;
    repeat (4) @(negedge i_clk);
  endtask

  task automatic readByte(input string tag);
    logic [7:0] exp_b;
    rd_ena = 1'b0;
    #1;
    exp_b = 8'h00;
    if (exp_q.size() > 0) begin
      exp_b    = exp_q.pop_front();
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
    end
    checkOutput({tag, "_data"}, {24'h0, data_out}, {24'h0, exp_b});
    @(negedge i_clk);
    rd_ena = 1'b1;
    #1;
    checkOutput({tag, "_ready"}, {31'h0, rx_ready}, {31'h0, exp_q.size() != 0});
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, "_ready"}, {31'h0, rx_ready}, {31'h0, exp_q.size() != 0});
    checkOutput({tag, "_ferr"}, {31'h0, framing_err}, {31'h0, exp_ferr});
    checkOutput({tag, "_ovr"}, {31'h0, overrun}, {31'h0, exp_ovr});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total    = 0;
    bad      = 0;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    rst_n    = 1'b0;
    rxd      = 1'b1;
    rd_ena   = 1'b1;
    repeat (3) @(negedge i_clk);
    rd_ena = 1'b0;
    #1;
    checkOutput("rst_data", {24'h0, data_out}, 32'h0);
    checkFlags("rst");
    rd_ena = 1'b1;
    @(negedge i_clk);
    rst_n = 1'b1;
    repeat (4) @(negedge i_clk);

    // Frame 0x41 with latency measured from the first posedge after the fall.
    lat = 0;
    fork
      applyStimulus(8'h41, 1'b1);
      begin
        @(posedge i_clk);
        while (!rx_ready && lat < 300) begin
          @(posedge i_clk);
          #1;
          lat++;
        end
      end
    join
    checkOutput("t1_latency", lat, 154);
    readByte("t1");

    // Short low pulse: false start.
    rxd = 1'b0;
    repeat (4) @(negedge i_clk);
    rxd = 1'b1;
    repeat (40) @(negedge i_clk);
    checkFlags("t2");

    // Bad stop bit, then a clean frame.
    applyStimulus(8'h55, 1'b0);
    checkFlags("t3a");
    applyStimulus(8'h3C, 1'b1);
    checkFlags("t3b");
    readByte("t3");
    checkFlags("t3c");

    // Overrun after five unread frames.
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1);
    checkFlags("t4a");
    for (int i = 0; i < 4; i++) readByte("t4");
    checkFlags("t4b");

    // Reset in the middle of a data bit of 0xFF.
    rxd = 1'b0;
    repeat (CPB) @(negedge i_clk);
    rxd = 1'b1;
    repeat (3 * CPB + CPB / 2) @(negedge i_clk);
    rst_n  = 1'b0;
    rd_ena = 1'b0;
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    #1;
    checkOutput("t5_rst_data", {24'h0, data_out}, 32'h0);
    checkFlags("t5_rst");
    @(negedge i_clk);
    rd_ena = 1'b1;
    @(negedge i_clk);
    rst_n = 1'b1;
    repeat (8 * CPB) @(negedge i_clk);
    checkFlags("t5_idle");
    applyStimulus(8'hA5, 1'b1);
    readByte("t5");

    // Full FIFO: pop lands on the same edge as the 0x77 push.
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h10 + i), 1'b1);
    fork
      applyStimulus(8'h77, 1'b1);
      begin
        @(posedge i_clk);
        repeat (153) @(posedge i_clk);
        @(negedge i_clk);
        readByte("t6_pop");
      end
    join
    checkFlags("t6a");
    checkOutput("t6_count", {28'h0, dut.u_fifo.count}, 32'd4);
    for (int i = 0; i < 4; i++) readByte("t6");
    checkFlags("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
